conv_puncture_serializer: RTL and testbench
===========================================

// Module: conv_puncture_serializer
// PURPOSE
//  Consumes the (out1,out2) coded-bit pair stream of the K=13 rate-1/2 convolutional
//  encoder, deletes bits per a periodic puncture pattern (default rate 3/4) and emits
//  the surviving bits serially over a valid/ready link toward the modulator/framer.
//  Holds one pair in flight, so upstream is throttled only while pair bits are pending.
// PARAMETERS
//  PERIOD  3       pairs per puncture period (1..16)
//  PAT_A   3'b011  keep mask for out1 bits; bit i = pair phase i (1=keep)
//  PAT_B   3'b101  keep mask for out2 bits; bit i = pair phase i (1=keep)
//  Legal: PAT_A[0]|PAT_B[0] must be 1 (phase 0 emits >=1 bit, carries SOF).
// PORTS
//  clock      in   1  sole clock, rising edge
//  reset      in   1  synchronous, active-high
//  in_valid   in   1  pair present
//  in_ready   out  1  pair accepted when in_valid&in_ready
//  in_a       in   1  encoder out1 bit
//  in_b       in   1  encoder out2 bit
//  in_sof     in   1  pair is first of a frame; forces pattern phase 0
//  out_valid  out  1  serial bit present
//  out_ready  in   1  sink accepts when out_valid&out_ready
//  out_bit    out  1  serial coded bit
//  out_sof    out  1  out_bit is first emitted bit of a frame
//  phase      out  4  pattern phase the next accepted pair will use
// BEHAVIOUR
//  State: buf_a, buf_b; km[1:0] = remaining kept bits (km[0]=A, km[1]=B); sof_p; phase.
//  Reset (cycle reset=1 sampled): km=0, sof_p=0, phase=0, buf=0 -> out_valid=0,
//   out_bit=0, out_sof=0, phase=0; in_ready=0 while reset high. Mid-operation reset
//   discards the held pair and pending bits; no partial bit emitted after reset.
//  out_valid = |km (registered). out_bit = km[0] ? buf_a : buf_b (A before B).
//  out_sof = sof_p & out_valid; sof_p clears on first out handshake.
//  Output handshake: clears lowest set bit of km.
//  in_ready = ~reset & (km==0 | (km one-hot & out_ready)) -- combinational on out_ready;
//   lets a new pair load the same cycle the last pending bit leaves.
//  Accept: p = in_sof ? 0 : phase; buf<={in_a,in_b}; km<={PAT_B[p],PAT_A[p]};
//   sof_p<=in_sof; phase<=(p==PERIOD-1)?0:p+1.
//  Fully punctured pair (km loads 0): consumed, nothing emitted, ready stays high.
//  Latency: accepted pair's first kept bit valid the next cycle.
//  Throughput: 1 bit/cycle when out_ready=1; rate 1/2 (all-ones pattern) -> in_ready
//   high every other cycle.
//  out_bit/out_sof hold stable while out_valid & ~out_ready. No bit dropped/duplicated.
//  in_sof mid-period: current pattern abandoned, pair uses phase 0; bits of previous
//   pair still pending are emitted first, in order.
// TESTING
//  T1 default pattern, pairs (1,0)(1,1)(0,1), out_ready=1 -> out_bit 1,0,1,1; phase 1,2,0.
//  T2 same stream, out_ready low 3 cycles mid-pair -> out_bit/out_valid held, in_ready=0,
//     final sequence unchanged.
//  T3 PAT_A=PAT_B=1'b1, PERIOD=1, continuous pairs -> 1 bit/cycle, in_ready 1,0,1,0...
//  T4 in_sof on 2nd pair of period -> that pair keeps A,B (phase 0), out_sof=1 on its A bit.
//  T5 reset asserted with km=2'b10 pending -> next cycle out_valid=0, phase=0, resume clean.
//  T6 PAT_A=3'b001,PAT_B=3'b001 -> phases 1,2 pairs consumed silently, 2 bits per 3 pairs.

Source files
------------

// File: rtl/conv_puncture_serializer.sv
// Punctures the (out1,out2) pair stream of a rate-1/2 convolutional encoder with a
// periodic keep pattern and serializes the surviving bits, A before B, one per cycle.
module conv_puncture_serializer #(
    parameter int                PERIOD = 3,
    parameter logic [PERIOD-1:0] PAT_A  = 3'b011,
    parameter logic [PERIOD-1:0] PAT_B  = 3'b101
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_a,
    input  logic       in_b,
    input  logic       in_sof,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_bit,
    output logic       out_sof,
    output logic [3:0] phase
);

    // Patterns widened to the full 4-bit phase range so indexing stays in bounds.
    localparam logic [15:0] PAT_A_EXT  = 16'(PAT_A);
    localparam logic [15:0] PAT_B_EXT  = 16'(PAT_B);
    localparam logic [3:0]  LAST_PHASE = 4'(PERIOD - 1);

    logic [1:0] km_q, km_d;
    logic       buf_a_q, buf_a_d;
    logic       buf_b_q, buf_b_d;
    logic       sof_p_q, sof_p_d;
    logic [3:0] phase_q, phase_d;

    logic [3:0] pair_phase;
    logic       km_one_hot;
    logic       in_fire;
    logic       out_fire;

    // Both links: a transfer happens on a rising edge where valid & ready are both high;
    // valid never depends on ready, and in_ready looks at out_ready so a new pair can
    // load in the same cycle the last pending bit of the held pair leaves.
    always_comb begin
        km_one_hot = (km_q == 2'b01) || (km_q == 2'b10);
        in_ready   = ~reset & ((km_q == 2'b00) | (km_one_hot & out_ready));
        out_valid  = |km_q;
        out_bit    = km_q[0] ? buf_a_q : buf_b_q;
        out_sof    = sof_p_q & out_valid;
        phase      = phase_q;
        in_fire    = in_valid & in_ready;
        out_fire   = out_valid & out_ready;
        pair_phase = in_sof ? 4'd0 : phase_q;
    end

    always_comb begin
        km_d    = km_q;
        buf_a_d = buf_a_q;
        buf_b_d = buf_b_q;
        sof_p_d = sof_p_q;
        phase_d = phase_q;
        if (out_fire) begin
            km_d    = km_q & (km_q - 2'd1);
            sof_p_d = 1'b0;
        end
        // A load only happens once the held pair is empty or leaving, so it overrides.
        if (in_fire) begin
            buf_a_d = in_a;
            buf_b_d = in_b;
            km_d    = {PAT_B_EXT[pair_phase], PAT_A_EXT[pair_phase]};
            sof_p_d = in_sof;
            phase_d = (pair_phase == LAST_PHASE) ? 4'd0 : pair_phase + 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            km_q    <= 2'b00;
            buf_a_q <= 1'b0;
            buf_b_q <= 1'b0;
            sof_p_q <= 1'b0;
            phase_q <= 4'd0;
        end else begin
            km_q    <= km_d;
            buf_a_q <= buf_a_d;
            buf_b_q <= buf_b_d;
            sof_p_q <= sof_p_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: tb/tb_conv_puncture_serializer.sv
// Directed bench for conv_puncture_serializer: three instances (rate 3/4, rate 1/2,
// sparse pattern) sharing clock and reset, one driven at a time.
module tb_conv_puncture_serializer;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid [3];
    logic       in_ready [3];
    logic       in_a     [3];
    logic       in_b     [3];
    logic       in_sof   [3];
    logic       out_valid[3];
    logic       out_ready[3];
    logic       out_bit  [3];
    logic       out_sof  [3];
    logic [3:0] phase    [3];

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] got_q[$];
    logic [1:0] exp_q[$];

    always #5 clock = ~clock;

    conv_puncture_serializer u_dut_r34 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_a(in_a[0]), .in_b(in_b[0]),
        .in_sof(in_sof[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_bit(out_bit[0]), .out_sof(out_sof[0]), .phase(phase[0])
    );

    conv_puncture_serializer #(.PERIOD(1), .PAT_A(1'b1), .PAT_B(1'b1)) u_dut_r12 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_a(in_a[1]), .in_b(in_b[1]),
        .in_sof(in_sof[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_bit(out_bit[1]), .out_sof(out_sof[1]), .phase(phase[1])
    );

    conv_puncture_serializer #(.PERIOD(3), .PAT_A(3'b001), .PAT_B(3'b001)) u_dut_sparse (
        .clock(clock), .reset(reset),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_a(in_a[2]), .in_b(in_b[2]),
        .in_sof(in_sof[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_bit(out_bit[2]), .out_sof(out_sof[2]), .phase(phase[2])
    );

    // Record every emitted bit as {sof, bit}; a bit under reset is not a transfer.
    always @(posedge clock) begin
        if (!reset) begin
            for (int d = 0; d < 3; d++) begin
                if (out_valid[d] && out_ready[d]) got_q.push_back({out_sof[d], out_bit[d]});
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            in_a[d]      = 1'b0;
            in_b[d]      = 1'b0;
            in_sof[d]    = 1'b0;
            out_ready[d] = 1'b1;
        end
        step();
        check("rst_in_ready_low", 32'(in_ready[0]), 32'd0);
        step();
        reset = 1'b0;
        #1;
        got_q.delete();
        exp_q.delete();
        check("rst_out_valid", 32'(out_valid[0]), 32'd0);
        check("rst_out_bit", 32'(out_bit[0]), 32'd0);
        check("rst_out_sof", 32'(out_sof[0]), 32'd0);
        check("rst_phase", 32'(phase[0]), 32'd0);
        check("rst_in_ready_high", 32'(in_ready[0]), 32'd1);
    endtask

    // Present one pair and hold it until accepted; returns 1ns after the accepting edge.
    task automatic send_pair(input int d, input logic a, input logic b, input logic sof);
        int n;
        in_valid[d] = 1'b1;
        in_a[d]     = a;
        in_b[d]     = b;
        in_sof[d]   = sof;
        #1;
        n = 0;
        while (!in_ready[d] && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) check("send_timeout", 32'(in_ready[d]), 32'd1);
        step();
        in_valid[d] = 1'b0;
        in_sof[d]   = 1'b0;
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (out_valid[d] && n < 40) begin
            step();
            n++;
        end
        check("drain_idle", 32'(out_valid[d]), 32'd0);
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check(tag, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [3:0] ta;
        logic [3:0] tb;
        logic [2:0] k;
        logic       accepted;

        // T1: rate 3/4 stream, sink always ready.
        do_reset();
        exp_q = '{2'b11, 2'b00, 2'b01, 2'b01};
        send_pair(0, 1'b1, 1'b0, 1'b1);
        check("t1_phase_a", 32'(phase[0]), 32'd1);
        check("t1_lat_valid", 32'(out_valid[0]), 32'd1);
        check("t1_lat_bit", 32'(out_bit[0]), 32'd1);
        check("t1_lat_sof", 32'(out_sof[0]), 32'd1);
        check("t1_busy_ready", 32'(in_ready[0]), 32'd0);
        send_pair(0, 1'b1, 1'b1, 1'b0);
        check("t1_phase_b", 32'(phase[0]), 32'd2);
        send_pair(0, 1'b0, 1'b1, 1'b0);
        check("t1_phase_c", 32'(phase[0]), 32'd0);
        drain(0);
        compare_stream("t1_stream");

        // T2: same stream with the sink stalled while the B bit is pending.
        do_reset();
        exp_q = '{2'b11, 2'b00, 2'b01, 2'b01};
        send_pair(0, 1'b1, 1'b0, 1'b1);
        step();
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        in_a[0]      = 1'b1;
        in_b[0]      = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("t2_hold_valid", 32'(out_valid[0]), 32'd1);
            check("t2_hold_bit", 32'(out_bit[0]), 32'd0);
            check("t2_hold_sof", 32'(out_sof[0]), 32'd0);
            check("t2_stall_ready", 32'(in_ready[0]), 32'd0);
            step();
        end
        out_ready[0] = 1'b1;
        send_pair(0, 1'b1, 1'b1, 1'b0);
        send_pair(0, 1'b0, 1'b1, 1'b0);
        drain(0);
        compare_stream("t2_stream");

        // T3: rate 1/2, continuous pairs; in_ready alternates, one bit per cycle.
        do_reset();
        exp_q = '{2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
        ta = 4'b0101;
        tb = 4'b0110;
        k  = 3'd0;
        in_valid[1] = 1'b1;
        in_a[1]     = ta[0];
        in_b[1]     = tb[0];
        in_sof[1]   = 1'b1;
        #1;
        for (int c = 0; c < 8; c++) begin
            check("t3_ready", 32'(in_ready[1]), (c % 2 == 0) ? 32'd1 : 32'd0);
            if (c > 0) check("t3_valid", 32'(out_valid[1]), 32'd1);
            check("t3_phase", 32'(phase[1]), 32'd0);
            accepted = in_ready[1];
            step();
            if (accepted) begin
                k = k + 3'd1;
                in_sof[1] = 1'b0;
                if (k < 3'd4) begin
                    in_a[1] = ta[k[1:0]];
                    in_b[1] = tb[k[1:0]];
                end else begin
                    in_valid[1] = 1'b0;
                end
            end
        end
        drain(1);
        compare_stream("t3_stream");

        // T4: in_sof on the second pair restarts the pattern at phase 0.
        do_reset();
        exp_q = '{2'b11, 2'b01, 2'b10, 2'b01, 2'b01};
        send_pair(0, 1'b1, 1'b1, 1'b1);
        check("t4_phase_a", 32'(phase[0]), 32'd1);
        send_pair(0, 1'b0, 1'b1, 1'b1);
        check("t4_phase_restart", 32'(phase[0]), 32'd1);
        send_pair(0, 1'b1, 1'b0, 1'b0);
        check("t4_phase_c", 32'(phase[0]), 32'd2);
        drain(0);
        compare_stream("t4_stream");

        // T5: reset while the B bit is still pending, then resume.
        do_reset();
        exp_q = '{2'b11, 2'b00, 2'b01};
        send_pair(0, 1'b1, 1'b0, 1'b1);
        step();
        check("t5_pending_valid", 32'(out_valid[0]), 32'd1);
        check("t5_pending_phase", 32'(phase[0]), 32'd1);
        out_ready[0] = 1'b0;
        reset = 1'b1;
        #1;
        check("t5_rst_ready", 32'(in_ready[0]), 32'd0);
        step();
        reset = 1'b0;
        out_ready[0] = 1'b1;
        #1;
        check("t5_post_valid", 32'(out_valid[0]), 32'd0);
        check("t5_post_phase", 32'(phase[0]), 32'd0);
        check("t5_post_sof", 32'(out_sof[0]), 32'd0);
        send_pair(0, 1'b0, 1'b1, 1'b0);
        drain(0);
        compare_stream("t5_stream");

        // T6: only phase 0 keeps bits; phases 1 and 2 are consumed silently.
        do_reset();
        exp_q = '{2'b11, 2'b00, 2'b00, 2'b01};
        send_pair(2, 1'b1, 1'b0, 1'b1);
        send_pair(2, 1'b1, 1'b1, 1'b0);
        check("t6_silent_valid", 32'(out_valid[2]), 32'd0);
        check("t6_silent_ready", 32'(in_ready[2]), 32'd1);
        check("t6_phase_b", 32'(phase[2]), 32'd2);
        send_pair(2, 1'b0, 1'b0, 1'b0);
        check("t6_silent_valid2", 32'(out_valid[2]), 32'd0);
        check("t6_phase_c", 32'(phase[2]), 32'd0);
        send_pair(2, 1'b0, 1'b1, 1'b0);
        check("t6_kept_valid", 32'(out_valid[2]), 32'd1);
        send_pair(2, 1'b1, 1'b1, 1'b0);
        send_pair(2, 1'b1, 1'b0, 1'b0);
        drain(2);
        compare_stream("t6_stream");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
